spm_datapath_gen: RTL and testbench
===================================

Name: spm_datapath_gen

Overview:
Parametrised next-generation datapath for the SPM CPU. It provides an NREG-deep register file, PC, IR, Y, ADDR and a three-bit flag register (Z, C, N). It also contains an extended ALU with a multi-cycle shift-add multiplier. It sits under the external control FSM, which drives all load/select/op strobes and reads ir_out, the flags and the multiplier handshake.

Parameters:
DW, 8, data/bus/PC/IR width (>=4)
NREG, 4, number of general registers (2..16)
SW, $clog2(NREG+1), width of sel_bus1 (derived, not overridden)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset
load_reg  in  NREG  one-hot-or-multi write enables for R[i] from bus_2
load_pc  in  1  load PC from bus_2
inc_pc  in  1  increment PC
load_ir  in  1  load IR from bus_2
load_y  in  1  load Y from bus_2
load_addr  in  1  load ADDR from bus_2
load_flags  in  1  update Z/C/N from ALU
sel_bus1  in  SW  bus_1 source select
sel_bus2  in  2  bus_2 source select
alu_op  in  4  ALU operation
mul_start  in  1  start multiply (Y * bus_1)
mem_word  in  DW  memory read data
bus_1  out  DW  bus_1 value
ir_out  out  DW  IR contents
addr_out  out  DW  ADDR contents
z_out, c_out, n_out  out  1 each  flag register
mul_busy  out  1  multiplier running
mul_done  out  1  one-cycle completion pulse

Behaviour:
- Reset: all registers (R[*], PC, IR, Y, ADDR), flags, multiplier result and FSM go to 0/IDLE immediately on rst low. mul_busy=0, mul_done=0.
- bus_1 (combinational): sel_bus1 < NREG selects R[sel]; sel_bus1 == NREG selects PC; any other value gives 0.
- bus_2 (combinational): 0 selects ALU result; 1 selects bus_1; 2 selects mem_word; 3 gives 0.
- Register writes take one cycle. Several load_reg bits may be set together; every selected register loads the same bus_2 value.
- PC: load_pc has priority over inc_pc. Increment wraps from 2^DW-1 to 0.
- ALU, A=Y, B=bus_1, all results DW bits:
  - 0 NOP: 0
  - 1 ADD: A+B, C = carry out
  - 2 SUB: B-A, C = borrow (B<A)
  - 3 AND: A&B
  - 4 NOT: ~B
  - 5 OR: A|B
  - 6 XOR: A^B
  - 7 SHL: B<<1, C = B[DW-1]
  - 8 SHR: B>>1 logical, C = B[0]
  - 9 MUL: last completed product (low DW bits), C = |high DW bits
  - 10-15: 0, C=0
  - Ops 3-6 force C=0.
  - Z = (result==0), N = result[DW-1].
- Flags update only on load_flags. load_flags while mul_busy=1 is ignored (flags hold).
- Multiplier FSM, states IDLE, RUN, DONE:
  - IDLE and mul_start=1: capture Y and bus_1, count=0, go to RUN.
  - RUN: one multiplier bit per cycle. After DW RUN cycles, write the 2*DW product register and go to DONE.
  - DONE: lasts one cycle, then IDLE.
  - mul_busy=1 exactly in RUN (DW cycles). mul_done=1 exactly in DONE.
  - mul_start in RUN or DONE is ignored; a start accepted in DONE does not exist, the next start is taken in IDLE.
  - The product register holds until the next completion.
  - Register/PC/IR loads stay legal while busy; operands are already captured.
- Reset mid-multiply: FSM goes to IDLE, product=0, no mul_done pulse.

Optional Feature:
DP_MUL_EN. When defined, the multiplier and its FSM are built as above. When undefined, MUL (op 9) returns 0 with C=0, mul_busy and mul_done are tied 0, mul_start is ignored, and load_flags is never blocked.

Decomposition:
- Package spm_dp_pkg: ALU op localparams (NOP..MUL), bus_2 select codes, multiplier state encoding.
- One sub-module, spm_dp_mul: the shift-add multiplier with FSM, busy/done outputs and product register, instantiated under DP_MUL_EN.
- Register file, PC and muxes are inline.

Test Plan:
1. rst low mid-run → all outputs 0; after release, bus_1=0 for every sel_bus1.
2. mem_word=0x5A, sel_bus2=2, load_reg=4'b0100 → next cycle, sel_bus1=2 gives bus_1=0x5A; sel_bus1=5 gives 0.
3. Y=0xF0, R1=0x20, alu_op=ADD, load_flags → result 0x10, C=1, Z=0, N=0. Then Y=0x20, SUB → Z=1, C=0.
4. load_pc with bus_2=0xFF, then inc_pc → PC 0x00. load_pc+inc_pc together with bus_2=0x10 → PC 0x10.
5. Y=0x0C, bus_1=0x0B, mul_start → mul_busy high for 8 cycles, mul_done pulses in cycle 9, MUL result 0x84, C=0. A repeated mul_start while busy has no effect. Y=0x10, bus_1=0x10 → result 0x00, Z=1, C=1.
6. rst asserted in RUN cycle 4 → mul_busy=0 immediately, no mul_done, MUL result 0x00.

Source files
------------

// File: rtl/spm_dp_pkg.sv
// Shared encodings for the SPM datapath: ALU opcodes, bus_2 sources, multiplier states.
package spm_dp_pkg;

   localparam logic [3:0] ALU_NOP = 4'd0;
   localparam logic [3:0] ALU_ADD = 4'd1;
   localparam logic [3:0] ALU_SUB = 4'd2;
   localparam logic [3:0] ALU_AND = 4'd3;
   localparam logic [3:0] ALU_NOT = 4'd4;
   localparam logic [3:0] ALU_OR  = 4'd5;
   localparam logic [3:0] ALU_XOR = 4'd6;
   localparam logic [3:0] ALU_SHL = 4'd7;
   localparam logic [3:0] ALU_SHR = 4'd8;
   localparam logic [3:0] ALU_MUL = 4'd9;

   localparam logic [1:0] B2_ALU  = 2'd0;
   localparam logic [1:0] B2_BUS1 = 2'd1;
   localparam logic [1:0] B2_MEM  = 2'd2;
   localparam logic [1:0] B2_ZERO = 2'd3;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_RUN  = 2'd1,
      MUL_DONE = 2'd2
   } mul_state_t;

endpackage

// File: rtl/spm_dp_mul.sv
// Shift-add multiplier: one multiplier bit per RUN cycle, DW RUN cycles, one DONE cycle.
module spm_dp_mul
   import spm_dp_pkg::*;
#(
   parameter int unsigned DW = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [DW-1:0]   a,
   input  logic [DW-1:0]   b,
   output logic            busy,
   output logic            done,
   output logic [2*DW-1:0] product
);

   localparam int unsigned CW = $clog2(DW);

   mul_state_t      state, state_next;
   logic [2*DW-1:0] mcand, acc, acc_next;
   logic [DW-1:0]   mplier;
   logic [CW-1:0]   count;
   logic            last;

   assign last     = (count == CW'(DW - 1));
   assign acc_next = acc + (mplier[0] ? mcand : '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= MUL_IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         MUL_IDLE: if (start) state_next = MUL_RUN;
         MUL_RUN: begin
            busy = 1'b1;
            if (last) state_next = MUL_DONE;
         end
         MUL_DONE: begin
            done       = 1'b1;
            state_next = MUL_IDLE;
         end
         default: state_next = MUL_IDLE;
      endcase
   end

   // Product is only written on the last RUN cycle, so it holds between completions.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mcand   <= '0;
         mplier  <= '0;
         acc     <= '0;
         count   <= '0;
         product <= '0;
      end else begin
         case (state)
            MUL_IDLE: if (start) begin
               mcand  <= (2*DW)'(a);
               mplier <= b;
               acc    <= '0;
               count  <= '0;
            end
            MUL_RUN: begin
               acc    <= acc_next;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               count  <= count + CW'(1);
               if (last) product <= acc_next;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/spm_datapath_gen.sv
// SPM CPU datapath: register file, PC/IR/Y/ADDR, Z/C/N flags and ALU.
// Define DP_MUL_EN to build the multi-cycle multiplier behind ALU op MUL.
module spm_datapath_gen
   import spm_dp_pkg::*;
#(
   parameter  int unsigned DW   = 8,
   parameter  int unsigned NREG = 4,
   localparam int unsigned SW   = $clog2(NREG + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREG-1:0] load_reg,
   input  logic            load_pc,
   input  logic            inc_pc,
   input  logic            load_ir,
   input  logic            load_y,
   input  logic            load_addr,
   input  logic            load_flags,
   input  logic [SW-1:0]   sel_bus1,
   input  logic [1:0]      sel_bus2,
   input  logic [3:0]      alu_op,
   input  logic            mul_start,
   input  logic [DW-1:0]   mem_word,
   output logic [DW-1:0]   bus_1,
   output logic [DW-1:0]   ir_out,
   output logic [DW-1:0]   addr_out,
   output logic            z_out,
   output logic            c_out,
   output logic            n_out,
   output logic            mul_busy,
   output logic            mul_done
);

   logic [DW-1:0]   regs [NREG];
   logic [DW-1:0]   pc, y, bus_2, alu_res;
   logic            alu_c;
   logic [DW:0]     sum, diff;
   logic [2*DW-1:0] mul_product;

`ifdef DP_MUL_EN
   spm_dp_mul #(.DW(DW)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (y),
      .b       (bus_1),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );
`else
   logic unused_mul_start;
   assign unused_mul_start = mul_start;
   assign mul_busy         = 1'b0;
   assign mul_done         = 1'b0;
   assign mul_product      = '0;
`endif

   always_comb begin
      bus_1 = '0;
      for (int unsigned i = 0; i < NREG; i++)
         if (sel_bus1 == SW'(i)) bus_1 = regs[i];
      if (sel_bus1 == SW'(NREG)) bus_1 = pc;
   end

   always_comb begin
      case (sel_bus2)
         B2_ALU:  bus_2 = alu_res;
         B2_BUS1: bus_2 = bus_1;
         B2_MEM:  bus_2 = mem_word;
         B2_ZERO: bus_2 = '0;
         default: bus_2 = '0;
      endcase
   end

   assign sum  = {1'b0, y} + {1'b0, bus_1};
   assign diff = {1'b0, bus_1} - {1'b0, y};

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      case (alu_op)
         ALU_ADD: {alu_c, alu_res} = sum;
         ALU_SUB: {alu_c, alu_res} = diff;
         ALU_AND: alu_res = y & bus_1;
         ALU_NOT: alu_res = ~bus_1;
         ALU_OR:  alu_res = y | bus_1;
         ALU_XOR: alu_res = y ^ bus_1;
         ALU_SHL: begin
            alu_res = {bus_1[DW-2:0], 1'b0};
            alu_c   = bus_1[DW-1];
         end
         ALU_SHR: begin
            alu_res = {1'b0, bus_1[DW-1:1]};
            alu_c   = bus_1[0];
         end
         ALU_MUL: begin
            alu_res = mul_product[DW-1:0];
            alu_c   = |mul_product[2*DW-1:DW];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
         pc       <= '0;
         ir_out   <= '0;
         y        <= '0;
         addr_out <= '0;
         z_out    <= 1'b0;
         c_out    <= 1'b0;
         n_out    <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < NREG; i++)
            if (load_reg[i]) regs[i] <= bus_2;
         if (load_pc)     pc <= bus_2;
         else if (inc_pc) pc <= pc + DW'(1);
         if (load_ir)   ir_out   <= bus_2;
         if (load_y)    y        <= bus_2;
         if (load_addr) addr_out <= bus_2;
         // Flags are frozen while the multiplier runs so the product's flags are not overwritten.
         if (load_flags && !mul_busy) begin
            z_out <= (alu_res == '0);
            c_out <= alu_c;
            n_out <= alu_res[DW-1];
         end
      end
   end

endmodule

// File: tb/tb_spm_datapath_gen.sv
// Scoreboard bench for spm_datapath_gen; multiplier checks follow DP_MUL_EN.
module tb_spm_datapath_gen;

   localparam int unsigned DW   = 8;
   localparam int unsigned NREG = 4;
   localparam int unsigned SW   = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic [NREG-1:0] load_reg;
   logic            load_pc, inc_pc, load_ir, load_y, load_addr, load_flags;
   logic [SW-1:0]   sel_bus1;
   logic [1:0]      sel_bus2;
   logic [3:0]      alu_op;
   logic            mul_start;
   logic [DW-1:0]   mem_word;
   logic [DW-1:0]   bus_1, ir_out, addr_out;
   logic            z_out, c_out, n_out, mul_busy, mul_done;

   always #5 clk = ~clk;

   spm_datapath_gen #(.DW(DW), .NREG(NREG)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_reg   (load_reg),
      .load_pc    (load_pc),
      .inc_pc     (inc_pc),
      .load_ir    (load_ir),
      .load_y     (load_y),
      .load_addr  (load_addr),
      .load_flags (load_flags),
      .sel_bus1   (sel_bus1),
      .sel_bus2   (sel_bus2),
      .alu_op     (alu_op),
      .mul_start  (mul_start),
      .mem_word   (mem_word),
      .bus_1      (bus_1),
      .ir_out     (ir_out),
      .addr_out   (addr_out),
      .z_out      (z_out),
      .c_out      (c_out),
      .n_out      (n_out),
      .mul_busy   (mul_busy),
      .mul_done   (mul_done)
   );

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   typedef struct {
      logic [3:0] op;
      logic [7:0] y;
      logic [7:0] b;
      logic [7:0] res;
      logic       c;
   } alu_vec_t;

   exp_t     sb[$];
   alu_vec_t vecs [11];
   int       n_cmp = 0;
   int       n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_val(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic compare_next(input logic [31:0] obs);
      exp_t e;
      if (sb.size() == 0) check_eq("sb_underflow", 32'(sb.size()), 32'd1);
      else begin
         e = sb.pop_front();
         check_eq(e.tag, obs, e.val);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ctl;
      load_reg   = '0;
      load_pc    = 1'b0;
      inc_pc     = 1'b0;
      load_ir    = 1'b0;
      load_y     = 1'b0;
      load_addr  = 1'b0;
      load_flags = 1'b0;
      mul_start  = 1'b0;
      sel_bus1   = '0;
      sel_bus2   = 2'd0;
      alu_op     = 4'd0;
   endtask

   task automatic write_reg(input int unsigned idx, input logic [DW-1:0] v);
      load_reg      = '0;
      load_reg[idx] = 1'b1;
      sel_bus2      = 2'd2;
      mem_word      = v;
      step;
      load_reg = '0;
   endtask

   task automatic write_y(input logic [DW-1:0] v);
      load_y   = 1'b1;
      sel_bus2 = 2'd2;
      mem_word = v;
      step;
      load_y = 1'b0;
   endtask

   task automatic read_reg(input string tag, input logic [SW-1:0] sel, input logic [DW-1:0] exp);
      sel_bus1 = sel;
      expect_val(tag, 32'(exp));
      #1;
      compare_next(32'(bus_1));
   endtask

   // B = R1; result captured in R3 and flags in the same cycle.
   task automatic alu_exec(input logic [3:0] op, input logic [DW-1:0] res, input logic c);
      sel_bus1   = 3'd1;
      alu_op     = op;
      load_flags = 1'b1;
      sel_bus2   = 2'd0;
      load_reg   = 4'b1000;
      expect_val($sformatf("op%0d_res", op), 32'(res));
      expect_val($sformatf("op%0d_z", op), 32'(res == 8'h00));
      expect_val($sformatf("op%0d_c", op), 32'(c));
      expect_val($sformatf("op%0d_n", op), 32'(res[DW-1]));
      step;
      clear_ctl;
      sel_bus1 = 3'd3;
      #1;
      compare_next(32'(bus_1));
      compare_next(32'(z_out));
      compare_next(32'(c_out));
      compare_next(32'(n_out));
   endtask

   task automatic check_all_zero(input string pfx);
      expect_val({pfx, "_ir"}, 32'd0);
      expect_val({pfx, "_addr"}, 32'd0);
      expect_val({pfx, "_zcn"}, 32'd0);
      expect_val({pfx, "_busy"}, 32'd0);
      expect_val({pfx, "_done"}, 32'd0);
      expect_val({pfx, "_bus1"}, 32'd0);
      #1;
      compare_next(32'(ir_out));
      compare_next(32'(addr_out));
      compare_next(32'({z_out, c_out, n_out}));
      compare_next(32'(mul_busy));
      compare_next(32'(mul_done));
      compare_next(32'(bus_1));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs = '{
         '{4'd1,  8'hF0, 8'h20, 8'h10, 1'b1},
         '{4'd2,  8'h20, 8'h20, 8'h00, 1'b0},
         '{4'd2,  8'h30, 8'h20, 8'hF0, 1'b1},
         '{4'd3,  8'hF0, 8'h3C, 8'h30, 1'b0},
         '{4'd7,  8'h00, 8'h81, 8'h02, 1'b1},
         '{4'd4,  8'hFF, 8'h3C, 8'hC3, 1'b0},
         '{4'd8,  8'h00, 8'h81, 8'h40, 1'b1},
         '{4'd5,  8'h0F, 8'h30, 8'h3F, 1'b0},
         '{4'd6,  8'hFF, 8'h0F, 8'hF0, 1'b0},
         '{4'd0,  8'h12, 8'h34, 8'h00, 1'b0},
         '{4'd12, 8'h12, 8'h34, 8'h00, 1'b0}
      };
      clear_ctl;
      mem_word = '0;
      rst      = 1'b0;
      #12;
      check_all_zero("por");
      step;
      rst = 1'b1;

      // IR, ADDR and register-file loads
      load_ir = 1'b1; sel_bus2 = 2'd2; mem_word = 8'hA5; step; load_ir = 1'b0;
      load_addr = 1'b1; mem_word = 8'h77; step; load_addr = 1'b0;
      expect_val("ir_load", 32'hA5);
      expect_val("addr_load", 32'h77);
      compare_next(32'(ir_out));
      compare_next(32'(addr_out));
      write_reg(2, 8'h5A);
      read_reg("r2_mem", 3'd2, 8'h5A);
      read_reg("sel5_zero", 3'd5, 8'h00);
      load_reg = 4'b1010; sel_bus2 = 2'd2; mem_word = 8'h3C; step; load_reg = '0;
      read_reg("multi_r1", 3'd1, 8'h3C);
      read_reg("multi_r3", 3'd3, 8'h3C);
      read_reg("multi_r2_hold", 3'd2, 8'h5A);
      sel_bus1 = 3'd2; sel_bus2 = 2'd1; load_reg = 4'b0001; step; load_reg = '0;
      read_reg("bus2_bus1", 3'd0, 8'h5A);
      sel_bus2 = 2'd3; mem_word = 8'hEE; load_reg = 4'b0001; step; load_reg = '0;
      read_reg("bus2_zero", 3'd0, 8'h00);

      // PC wrap and load priority
      sel_bus2 = 2'd2; mem_word = 8'hFF; load_pc = 1'b1; step; load_pc = 1'b0;
      read_reg("pc_load", 3'd4, 8'hFF);
      inc_pc = 1'b1; step; inc_pc = 1'b0;
      read_reg("pc_wrap", 3'd4, 8'h00);
      mem_word = 8'h10; load_pc = 1'b1; inc_pc = 1'b1; step; load_pc = 1'b0; inc_pc = 1'b0;
      read_reg("pc_prio", 3'd4, 8'h10);
      inc_pc = 1'b1; step; inc_pc = 1'b0;
      read_reg("pc_inc", 3'd4, 8'h11);

      // asynchronous reset mid-run
      sel_bus1 = 3'd2;
      rst = 1'b0;
      check_all_zero("rst_mid");
      step;
      rst = 1'b1;
      for (int i = 0; i < 8; i++) read_reg($sformatf("post_rst_sel%0d", i), 3'(i), 8'h00);

      for (int i = 0; i < 11; i++) begin
         write_y(vecs[i].y);
         write_reg(1, vecs[i].b);
         alu_exec(vecs[i].op, vecs[i].res, vecs[i].c);
      end

      // flags hold without load_flags: last flags were Z=1,C=0,N=0
      write_y(8'hF0); write_reg(1, 8'h20);
      sel_bus1 = 3'd1; alu_op = 4'd1; step; clear_ctl;
      expect_val("flags_hold", 32'b100);
      compare_next(32'({z_out, c_out, n_out}));

`ifdef DP_MUL_EN
      alu_op = 4'd0; load_flags = 1'b1; step; clear_ctl;
      write_y(8'h0C); write_reg(1, 8'h0B);
      sel_bus1 = 3'd1; mul_start = 1'b1; step; clear_ctl;
      for (int i = 1; i <= 11; i++) begin
         expect_val($sformatf("busy_c%0d", i), 32'(i <= 8));
         expect_val($sformatf("done_c%0d", i), 32'(i == 9));
         #1;
         compare_next(32'(mul_busy));
         compare_next(32'(mul_done));
         sel_bus1  = 3'd1;
         mul_start = (i == 3 || i == 9);
         if (i == 4) begin load_y = 1'b1; sel_bus2 = 2'd2; mem_word = 8'hFF; end
         if (i == 5) begin load_flags = 1'b1; alu_op = 4'd1; end
         step;
         clear_ctl;
      end
      expect_val("flags_blocked", 32'b100);
      compare_next(32'({z_out, c_out, n_out}));
      alu_exec(4'd9, 8'h84, 1'b0);

      write_y(8'h10); write_reg(1, 8'h10);
      sel_bus1 = 3'd1; mul_start = 1'b1; step; clear_ctl;
      repeat (10) step;
      alu_exec(4'd9, 8'h00, 1'b1);

      write_y(8'h0C); write_reg(1, 8'h0B);
      sel_bus1 = 3'd1; mul_start = 1'b1; step; clear_ctl;
      repeat (3) step;
      expect_val("busy_before_rst", 32'd1);
      #1;
      compare_next(32'(mul_busy));
      rst = 1'b0;
      expect_val("busy_rst", 32'd0);
      expect_val("done_rst", 32'd0);
      #1;
      compare_next(32'(mul_busy));
      compare_next(32'(mul_done));
      step;
      rst = 1'b1;
      for (int i = 0; i < 12; i++) begin
         expect_val($sformatf("no_done_%0d", i), 32'd0);
         #1;
         compare_next(32'(mul_done));
         step;
      end
      alu_exec(4'd9, 8'h00, 1'b0);
`else
      write_y(8'hF0); write_reg(1, 8'h20);
      alu_exec(4'd1, 8'h10, 1'b1);
      for (int i = 0; i < 3; i++) begin
         mul_start = 1'b1;
         step;
         expect_val($sformatf("nomul_busy%0d", i), 32'd0);
         expect_val($sformatf("nomul_done%0d", i), 32'd0);
         #1;
         compare_next(32'(mul_busy));
         compare_next(32'(mul_done));
      end
      mul_start = 1'b1;
      alu_exec(4'd9, 8'h00, 1'b0);
`endif

      check_eq("sb_leftover", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
